// File: rtl/cargador_banco_if.sv
// Stream + register-bank port bundle between the boot/debug source, the loader and the bank.
// slave: the loader's view; master: the source/bank side.
interface cargador_banco_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              Start;
  logic [DATA_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] Write_Reg;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Read_Reg1;
  logic [DATA_W-1:0] Read_data1;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [DATA_W-1:0] Checksum;

  modport slave (
    input  Start, In_Data, In_Valid, Read_data1,
    output In_Ready, Write_Reg, Write_Data, RegWrite, Read_Reg1,
           Busy, Done, Error, Checksum
  );

  modport master (
    output Start, In_Data, In_Valid, Read_data1,
    input  In_Ready, Write_Reg, Write_Data, RegWrite, Read_Reg1,
           Busy, Done, Error, Checksum
  );
endinterface

// File: rtl/cargador_banco.sv
// Sequential register-bank loader: streams NUM_REGS words into the bank, then
// reads them back and compares XOR checksums.
module cargador_banco #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cargador_banco_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_wsum;
  logic [DATA_W-1:0] r_rsum;
  logic              r_in_ready;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [ADDR_W-1:0] r_read_reg1;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [DATA_W-1:0] r_checksum;

  logic w_hs;
  logic w_last_wr;
  logic w_last_rd;

  assign w_hs      = bus.In_Valid & r_in_ready;
  assign w_last_wr = (r_idx == LAST_IDX);
  assign w_last_rd = (r_read_reg1 == LAST_IDX);

  assign bus.In_Ready   = r_in_ready;
  assign bus.Write_Reg  = r_write_reg;
  assign bus.Write_Data = r_write_data;
  assign bus.RegWrite   = r_regwrite;
  assign bus.Read_Reg1  = r_read_reg1;
  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.Error      = r_error;
  assign bus.Checksum   = r_checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_wsum       <= '0;
      r_rsum       <= '0;
      r_in_ready   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_read_reg1  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_checksum   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_END: begin
          if (bus.Start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_wsum     <= '0;
            r_rsum     <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        // Two-cycle write: accept, then hold address/data for one RegWrite cycle
        // since the bank writes level-sensitively.
        S_LOAD: begin
          if (r_regwrite) begin
            r_regwrite <= 1'b0;
            if (w_last_wr) begin
              r_idx       <= '0;
              r_read_reg1 <= '0;
              r_state     <= S_VERIFY;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_in_ready <= 1'b1;
            end
          end else if (w_hs) begin
            r_write_reg  <= r_idx;
            r_write_data <= bus.In_Data;
            r_regwrite   <= 1'b1;
            r_in_ready   <= 1'b0;
            r_wsum       <= r_wsum ^ bus.In_Data;
          end
        end

        S_VERIFY: begin
          r_rsum <= r_rsum ^ bus.Read_data1;
          if (w_last_rd) begin
            r_read_reg1 <= '0;
            r_state     <= S_CHECK;
          end else begin
            r_read_reg1 <= r_read_reg1 + 1'b1;
          end
        end

        S_CHECK: begin
          r_checksum <= r_wsum;
          if (r_rsum == r_wsum) r_done  <= 1'b1;
          else                  r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_END;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cargador_banco.sv
// Directed bench for cargador_banco with a behavioural 32x32 bank model.
module tb_cargador_banco;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cargador_banco_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  cargador_banco #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] bank [32];
  logic [31:0] words [32];
  bit          corrupt = 1'b0;

  always @(posedge clk) if (bus.RegWrite) bank[bus.Write_Reg] <= bus.Write_Data;
  assign bus.Read_data1 = (corrupt && bus.Read_Reg1 == 5'd7) ? 32'hDEADBEEF : bank[bus.Read_Reg1];

  int checks = 0;
  int errors = 0;
  int nwr, order_err, hs_err, pulse_err, kdone;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_in_ready"}, 32'(bus.In_Ready), 0);
    chk({p, "_regwrite"}, 32'(bus.RegWrite), 0);
    chk({p, "_busy"}, 32'(bus.Busy), 0);
    chk({p, "_done"}, 32'(bus.Done), 0);
    chk({p, "_error"}, 32'(bus.Error), 0);
    chk({p, "_write_reg"}, 32'(bus.Write_Reg), 0);
    chk({p, "_write_data"}, bus.Write_Data, 0);
    chk({p, "_read_reg1"}, 32'(bus.Read_Reg1), 0);
    chk({p, "_checksum"}, bus.Checksum, 0);
  endtask

  // Drives the stream until Done/Error; kdone = edges after the Start edge.
  task automatic run(input bit do_start, input bit stalls, input bit busy_starts);
    int sent, k;
    bit prev_hs, prev_rw;
    nwr = 0; order_err = 0; hs_err = 0; pulse_err = 0; kdone = -1;
    sent = 0; k = 0; prev_hs = 0; prev_rw = 0;
    if (do_start) begin
      bus.Start = 1'b1; step(); bus.Start = 1'b0;
    end
    while (k < 400) begin
      bus.In_Valid = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.In_Data  = (bus.In_Valid && sent < 32) ? words[sent] : (32'hBAD00000 | 32'(k));
      bus.Start    = busy_starts && (k == 5 || k == 70);
      prev_hs      = bus.In_Valid && bus.In_Ready;
      step(); k++;
      if (prev_hs) sent++;
      if (bus.RegWrite) begin
        nwr++;
        if (!prev_hs) hs_err++;
        if (prev_rw) pulse_err++;
        if (nwr > 32 || bus.Write_Reg !== 5'(nwr - 1) || bus.Write_Data !== words[nwr - 1])
          order_err++;
      end
      prev_rw = bus.RegWrite;
      if (bus.Done || bus.Error) begin
        kdone = k;
        break;
      end
    end
    bus.Start = 1'b0; bus.In_Valid = 1'b0;
    chk("run_timeout", 32'(kdone != -1), 1);
    chk("run_nwrites", 32'(nwr), 32);
    chk("run_order", 32'(order_err), 0);
    chk("run_hs_before_write", 32'(hs_err), 0);
    chk("run_single_pulse", 32'(pulse_err), 0);
  endtask

  function automatic int bank_mismatch();
    int m = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== words[i]) m++;
    return m;
  endfunction

  initial begin
    int sent, k;
    bit hs;
    logic [31:0] exp_sum;
    bus.Start = 0; bus.In_Valid = 0; bus.In_Data = 0;

    // Reset
    rst = 1; step(); step();
    chk_zero("reset");
    rst = 0; step();

    // Full load, no stalls
    for (int i = 0; i < 32; i++) words[i] = 32'(i) * 32'h01010101;
    run(1, 0, 0);
    chk("full_edges", 32'(kdone), 97);
    chk("full_bank", 32'(bank_mismatch()), 0);
    chk("full_checksum", bus.Checksum, 32'h0);
    chk("full_done", 32'(bus.Done), 1);
    chk("full_error", 32'(bus.Error), 0);
    chk("full_busy", 32'(bus.Busy), 0);

    // Random In_Valid gaps
    for (int i = 0; i < 32; i++) words[i] = 32'hA5A50000 + 32'(i);
    run(1, 1, 0);
    chk("stall_bank", 32'(bank_mismatch()), 0);
    chk("stall_checksum", bus.Checksum, 32'h0);
    chk("stall_done", 32'(bus.Done), 1);

    // Corrupted read-back of register 7
    exp_sum = 0;
    for (int i = 0; i < 32; i++) begin
      words[i] = 32'h12340000 + 32'(i * i);
      exp_sum ^= words[i];
    end
    corrupt = 1;
    run(1, 0, 0);
    corrupt = 0;
    chk("corrupt_error", 32'(bus.Error), 1);
    chk("corrupt_done", 32'(bus.Done), 0);
    chk("corrupt_checksum", bus.Checksum, exp_sum);

    // Reset mid-LOAD, during the RegWrite following the 10th handshake
    for (int i = 0; i < 32; i++) words[i] = 32'h5A000000 ^ (32'(i) << 4);
    bus.Start = 1; step(); bus.Start = 0;
    sent = 0; k = 0;
    while (!(sent == 10 && bus.RegWrite) && k < 100) begin
      bus.In_Valid = 1; bus.In_Data = words[sent];
      hs = bus.In_Valid && bus.In_Ready;
      step(); k++;
      if (hs) sent++;
    end
    chk("midload_in_write", 32'(bus.RegWrite), 1);
    chk("midload_write_reg", 32'(bus.Write_Reg), 9);
    rst = 1; bus.In_Valid = 0; step();
    chk("midload_rw_drop", 32'(bus.RegWrite), 0);
    chk("midload_busy", 32'(bus.Busy), 0);
    step();
    chk_zero("midload");
    rst = 0; step();
    run(1, 0, 0);
    chk("reload_edges", 32'(kdone), 97);
    chk("reload_bank", 32'(bank_mismatch()), 0);
    chk("reload_done", 32'(bus.Done), 1);

    // Start while busy is ignored
    for (int i = 0; i < 32; i++) words[i] = 32'hC0DE0000 + 32'(i * 7);
    exp_sum = 0;
    for (int i = 0; i < 32; i++) exp_sum ^= words[i];
    run(1, 0, 1);
    chk("busystart_edges", 32'(kdone), 97);
    chk("busystart_done", 32'(bus.Done), 1);
    chk("busystart_checksum", bus.Checksum, exp_sum);

    // Start in END clears Done and restarts LOAD
    bus.Start = 1; step(); bus.Start = 0;
    chk("endstart_done_clr", 32'(bus.Done), 0);
    chk("endstart_busy", 32'(bus.Busy), 1);
    chk("endstart_in_ready", 32'(bus.In_Ready), 1);
    run(0, 0, 0);
    chk("endstart_edges", 32'(kdone), 97);
    chk("endstart_done", 32'(bus.Done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
